// File: rtl/mod_step_counter.sv
// mod_step_counter: up/down modulo counter with parallel load, programmable
// step, wrap pulse, sticky wrap flag and an active-low seven-segment hex bank.
// Optional feature macro: MOD_STEP_COUNTER_SATURATE_EN (saturate instead of wrap).
module mod_step_counter #(
    parameter int              WIDTH   = 16,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP    = 64'd1,
    localparam int             NDIGITS = (WIDTH + 3) / 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 up,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     count,
    output logic                 tc,
    output logic                 wrap,
    output logic                 ovf,
    output logic [7*NDIGITS-1:0] hex
);

    // One extra bit so count+STEP and count+modulus never overflow.
    localparam logic [WIDTH:0] C_MAX  = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH:0] C_STEP = STEP[WIDTH:0];
    localparam logic [WIDTH:0] C_MOD  = C_MAX + {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]     r_count;
    logic                 r_wrap;
    logic                 r_ovf;

    logic [WIDTH-1:0]     w_count_nxt;
    logic                 w_wrap_nxt;
    logic                 w_ovf_nxt;
    logic [WIDTH:0]       w_ext;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_up_wrap;
    logic [WIDTH:0]       w_dn_wrap;
    logic [WIDTH:0]       w_dn;
    logic                 w_up_over;
    logic                 w_dn_under;
    logic [WIDTH-1:0]     w_ld;
    logic [4*NDIGITS-1:0] w_pad;

    assign w_ext      = {1'b0, r_count};
    assign w_sum      = w_ext + C_STEP;
    assign w_up_wrap  = w_sum - C_MOD;
    assign w_dn_wrap  = w_ext + C_MOD - C_STEP;
    assign w_dn       = w_ext - C_STEP;
    assign w_up_over  = (w_sum > C_MAX);
    assign w_dn_under = (w_ext < C_STEP);
    assign w_ld       = ({1'b0, load_val} > C_MAX) ? C_MAX[WIDTH-1:0] : load_val;

    // Next-state selection: clear beats load beats count; no enable holds.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_ovf_nxt   = r_ovf;
        if (clear) begin
            w_count_nxt = '0;
            w_ovf_nxt   = 1'b0;
        end else if (load) begin
            w_count_nxt = w_ld;
        end else if (en) begin
            if (up) begin
                if (w_up_over) begin
`ifdef MOD_STEP_COUNTER_SATURATE_EN
                    w_count_nxt = C_MAX[WIDTH-1:0];
`else
                    w_count_nxt = w_up_wrap[WIDTH-1:0];
`endif
                    w_wrap_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_count_nxt = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_under) begin
`ifdef MOD_STEP_COUNTER_SATURATE_EN
                    w_count_nxt = '0;
`else
                    w_count_nxt = w_dn_wrap[WIDTH-1:0];
`endif
                    w_wrap_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_count_nxt = w_dn[WIDTH-1:0];
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    assign tc    = up ? (r_count == C_MAX[WIDTH-1:0]) : (r_count == '0);

    // Active-low glyph for one hex nibble; bit 0 = seg a, bit 6 = seg g.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Zero-pad the count up to a whole number of nibbles.
    generate
        if (4 * NDIGITS == WIDTH) begin : g_nopad
            assign w_pad = r_count;
        end else begin : g_pad
            assign w_pad = {{(4 * NDIGITS - WIDTH){1'b0}}, r_count};
        end
        for (genvar k = 0; k < NDIGITS; k++) begin : g_dig
            assign hex[7*k +: 7] = seg7(w_pad[4*k +: 4]);
        end
    endgenerate

endmodule

// File: tb/tb_mod_step_counter.sv
// Directed bench for mod_step_counter: a vector table on the default-size
// counter plus hand sequences for small moduli, clamping, reset and
// (when MOD_STEP_COUNTER_SATURATE_EN is defined) saturation.
module tb_mod_step_counter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;

    logic [15:0] c0;  logic t0, w0, o0; logic [27:0] h0;
    logic [3:0]  c1;  logic t1, w1, o1; logic [6:0]  h1;
    logic [7:0]  c2;  logic t2, w2, o2; logic [13:0] h2;
    logic [3:0]  c3;  logic t3, w3, o3; logic [6:0]  h3;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_step_counter u0 (.clk(clk), .resetn(resetn), .clear(clear), .en(en), .up(up),
        .load(load), .load_val(load_val), .count(c0), .tc(t0), .wrap(w0), .ovf(o0), .hex(h0));
    mod_step_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1)) u1 (.clk(clk), .resetn(resetn),
        .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .count(c1), .tc(t1), .wrap(w1), .ovf(o1), .hex(h1));
    mod_step_counter #(.WIDTH(8), .MAX_VAL(99), .STEP(7)) u2 (.clk(clk), .resetn(resetn),
        .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
        .count(c2), .tc(t2), .wrap(w2), .ovf(o2), .hex(h2));
    mod_step_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(4)) u3 (.clk(clk), .resetn(resetn),
        .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .count(c3), .tc(t3), .wrap(w3), .ovf(o3), .hex(h3));

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [27:0] hex16(input logic [15:0] v);
        return {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        clr, ld, e, u;
        logic [15:0] lv;
        logic [15:0] cnt;
        logic        tc, wr, of;
    } vec_t;

    vec_t vt[13];

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //           clr ld  en  up  load_val  count    tc  wrap ovf
        vt[0]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0001,1'b0,1'b0,1'b0};
        vt[1]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0002,1'b0,1'b0,1'b0};
        vt[2]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0003,1'b0,1'b0,1'b0};
        vt[3]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0004,1'b0,1'b0,1'b0};
        vt[4]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0005,1'b0,1'b0,1'b0};
        vt[5]  = '{1'b0,1'b1,1'b1,1'b1,16'h1234,16'h1234,1'b0,1'b0,1'b0};
        vt[6]  = '{1'b1,1'b1,1'b1,1'b1,16'h5555,16'h0000,1'b0,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b0,1'b1,1'b0,16'h0000,16'hFFFF,1'b0,1'b1,1'b1};
        vt[8]  = '{1'b0,1'b0,1'b1,1'b1,16'h0000,16'h0000,1'b0,1'b1,1'b1};
        vt[9]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,1'b1,1'b0,1'b1};
        vt[10] = '{1'b0,1'b1,1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,1'b0,1'b1};
        vt[11] = '{1'b0,1'b0,1'b1,1'b0,16'h0000,16'hFFFE,1'b0,1'b0,1'b1};
        vt[12] = '{1'b0,1'b1,1'b0,1'b1,16'hBEEF,16'hBEEF,1'b0,1'b0,1'b1};

        // reset state
        #12;
        check("rst_count", 32'(c0), 32'h0);
        check("rst_hex", 32'(h0), 32'({4{7'b1000000}}));
        check("rst_wrap_ovf", {30'd0, w0, o0}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // default counter vector table
        for (int i = 0; i < 13; i++) begin
            clear = vt[i].clr; load = vt[i].ld; en = vt[i].e; up = vt[i].u;
            load_val = vt[i].lv;
            tick();
            check($sformatf("v%0d_count", i), 32'(c0), 32'(vt[i].cnt));
            check($sformatf("v%0d_tc", i), 32'(t0), 32'(vt[i].tc));
            check($sformatf("v%0d_wrap", i), 32'(w0), 32'(vt[i].wr));
            check($sformatf("v%0d_ovf", i), 32'(o0), 32'(vt[i].of));
            check($sformatf("v%0d_hex", i), 32'(h0), 32'(hex16(vt[i].cnt)));
            if (i == 4) begin
                check("hex_d0_five", 32'(h0[6:0]), 32'h12);
                check("hex_d1_zero", 32'(h0[13:7]), 32'h40);
            end
        end
        check("hex_beef", 32'(h0), 32'({7'h03, 7'h06, 7'h06, 7'h0E}));

        // asynchronous reset mid-cycle
        load = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        check("async_count", 32'(c0), 32'h0);
        check("async_hex", 32'(h0), 32'({4{7'b1000000}}));
        check("async_ovf", 32'(o0), 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // WIDTH=4 MAX=9 STEP=1 wrap
        clear = 1'b1; tick(); clear = 1'b0;
        load = 1'b1; load_val = 16'd9; up = 1'b1; tick(); load = 1'b0;
        check("m9_load_count", 32'(c1), 32'd9);
        check("m9_tc", 32'(t1), 32'd1);
        en = 1'b1; tick();
        check("m9_wrap_count", 32'(c1), 32'd0);
        check("m9_wrap", 32'(w1), 32'd1);
        check("m9_ovf", 32'(o1), 32'd1);
        tick();
        check("m9_next_count", 32'(c1), 32'd1);
        check("m9_wrap_drop", 32'(w1), 32'd0);
        check("m9_ovf_sticky", 32'(o1), 32'd1);
        en = 1'b0;

        // WIDTH=8 MAX=99 STEP=7 down wrap and load clamp
        load = 1'b1; load_val = 16'd3; tick(); load = 1'b0;
        en = 1'b1; up = 1'b0; tick(); en = 1'b0;
        check("m99_dn_count", 32'(c2), 32'd96);
        check("m99_dn_wrap", 32'(w2), 32'd1);
        load = 1'b1; load_val = 16'd200; tick(); load = 1'b0;
        check("m99_clamp", 32'(c2), 32'd99);
        check("m99_clamp_wrap", 32'(w2), 32'd0);

        // MAX=9 STEP=4: saturation or wrap depending on build
        load = 1'b1; load_val = 16'd8; tick(); load = 1'b0;
        en = 1'b1; up = 1'b1; tick();
`ifdef MOD_STEP_COUNTER_SATURATE_EN
        check("s4_up_count", 32'(c3), 32'd9);
        check("s4_up_wrap", 32'(w3), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("s4_hold%0d_count", k), 32'(c3), 32'd9);
            check($sformatf("s4_hold%0d_wrap", k), 32'(w3), 32'd1);
        end
`else
        check("s4_up_count", 32'(c3), 32'd2);
        check("s4_up_wrap", 32'(w3), 32'd1);
        tick();
        check("s4_next_count", 32'(c3), 32'd6);
        check("s4_next_wrap", 32'(w3), 32'd0);
`endif
        en = 1'b0;
        load = 1'b1; load_val = 16'd2; tick(); load = 1'b0;
        en = 1'b1; up = 1'b0; tick(); en = 1'b0;
`ifdef MOD_STEP_COUNTER_SATURATE_EN
        check("s4_dn_count", 32'(c3), 32'd0);
`else
        check("s4_dn_count", 32'(c3), 32'd8);
`endif
        check("s4_dn_wrap", 32'(w3), 32'd1);
        check("s4_dn_ovf", 32'(o3), 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
